// File: rtl/captura_jogada.sv
// Button-capture front end: synchronizes and debounces the raw buttons, accepts one
// one-hot play per physical press and tracks per-play inactivity.
module captura_jogada #(
  parameter int unsigned DEBOUNCE = 5,
  parameter int unsigned TIMEOUT  = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       habilita,
  input  logic       limpa,
  output logic [3:0] jogada,
  output logic       tem_jogada,
  output logic       invalida,
  output logic       timeout,
  output logic [1:0] db_estado
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    LIVRE         = 2'd0,
    FILTRANDO     = 2'd1,
    ESPERA_SOLTAR = 2'd2
  } estado_t;

  estado_t       estado, estado_n;
  logic [3:0]    sync_a, sync;
  logic [3:0]    candidato, candidato_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [3:0]    jogada_n;
  logic          tem_jogada_n, invalida_n, timeout_n;
  logic          aceita, rejeita;

  // State, synchronizer and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_a     <= '0;
      sync       <= '0;
      estado     <= LIVRE;
      candidato  <= '0;
      cnt        <= '0;
      tcnt       <= '0;
      jogada     <= '0;
      tem_jogada <= 1'b0;
      invalida   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      sync_a     <= botoes;
      sync       <= sync_a;
      estado     <= estado_n;
      candidato  <= candidato_n;
      cnt        <= cnt_n;
      tcnt       <= tcnt_n;
      jogada     <= jogada_n;
      tem_jogada <= tem_jogada_n;
      invalida   <= invalida_n;
      timeout    <= timeout_n;
    end
  end

  // Next-state, debounce counting and output decode
  always_comb begin
    estado_n     = estado;
    candidato_n  = candidato;
    cnt_n        = cnt;
    jogada_n     = jogada;
    tem_jogada_n = 1'b0;
    invalida_n   = 1'b0;
    tcnt_n       = tcnt;
    timeout_n    = timeout;
    aceita       = 1'b0;
    rejeita      = 1'b0;

    case (estado)
      LIVRE: begin
        if (sync != 4'd0) begin
          cnt_n = '0;
          if (habilita) begin
            candidato_n = sync;
            cnt_n       = CW'(1);
            estado_n    = FILTRANDO;
          end else begin
            estado_n = ESPERA_SOLTAR;
          end
        end
      end
      FILTRANDO: begin
        if (!habilita) begin
          estado_n = ESPERA_SOLTAR;
          cnt_n    = '0;
        end else if (sync == 4'd0) begin
          estado_n = LIVRE;
          cnt_n    = '0;
        end else if (sync != candidato) begin
          candidato_n = sync;
          cnt_n       = CW'(1);
        end else if (cnt == CW'(DEBOUNCE - 1)) begin
          estado_n = ESPERA_SOLTAR;
          cnt_n    = '0;
          if ($onehot(candidato)) aceita = 1'b1;
          else                    rejeita = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ESPERA_SOLTAR: begin
        // Any nonzero sample restarts the release window
        if (sync != 4'd0) begin
          cnt_n = '0;
        end else if (cnt == CW'(DEBOUNCE - 1)) begin
          estado_n = LIVRE;
          cnt_n    = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        estado_n = LIVRE;
        cnt_n    = '0;
      end
    endcase

    // Clear wins over a same-cycle acceptance; the FSM transition is kept
    if (limpa) begin
      jogada_n = 4'd0;
    end else begin
      if (aceita) jogada_n = candidato;
      tem_jogada_n = aceita;
      invalida_n   = rejeita;
    end

    // Inactivity counter saturates at TIMEOUT; the flag is sticky across plays
    if (!habilita || limpa) begin
      tcnt_n    = '0;
      timeout_n = 1'b0;
    end else if (aceita) begin
      tcnt_n = '0;
    end else begin
      if (tcnt != TW'(TIMEOUT)) tcnt_n = tcnt + TW'(1);
      if (tcnt_n == TW'(TIMEOUT)) timeout_n = 1'b1;
    end
  end

  assign db_estado = estado;

endmodule
